seq_mult_4x4: RTL and testbench
===============================

// Module: seq_mult_4x4
// PURPOSE
//   Sequential shift-add unsigned multiplier, N x N -> 2N bits, one partial product per clock.
//   Controller plus datapath of the 4x4 multiplier.
//   Consumes the operand pair selected by the upstream mux_2bit-based operand-select stage.
//   Produces a registered product with a start/done handshake for the downstream consumer.
// PARAMETERS
//   N   4   operand width in bits; product width is 2N; iteration count is N
// PORTS
//   clk      in   1    rising-edge clock; the only clock
//   rst      in   1    reset, synchronous, active-high
//   start    in   1    request; sampled only in IDLE
//   a        in   N    multiplicand; captured on accepted start
//   b        in   N    multiplier; captured on accepted start
//   busy     out  1    high in LOAD/CALC/DONE states, low in IDLE
//   done     out  1    one-cycle pulse; product valid from this cycle on
//   product  out  2N   result; held until the next accepted start
// BEHAVIOUR
//   Clock and reset
//     - One clock, clk.
//     - Reset is synchronous and active-high, port rst; it takes priority over all else.
//     - Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
//   States: IDLE -> LOAD -> CALC (N cycles) -> DONE -> IDLE
//     - IDLE: busy=0. If start=1, go to LOAD; otherwise stay.
//     - LOAD: M<=a, Q<=b, ACC<=0, C<=0, cnt<=0 (a/b captured at the edge leaving IDLE).
//     - CALC: if Q[0]=1, {C,ACC} = ACC + M (N+1-bit add), else {C,ACC} = {0,ACC}.
//       Then {C,ACC,Q} is shifted right by 1 with 0 shifted in at the MSB.
//       cnt increments; after the cycle with cnt==N-1, go to DONE.
//     - DONE: product<={ACC,Q}, done=1 for exactly this cycle, then go to IDLE.
//   Latency
//     - Start accepted at edge k puts done high in the cycle after edge k+N+1.
//     - For N=4: done is seen 6 cycles after start is sampled, 1+1+4 states.
//   Arithmetic
//     - Unsigned only; no overflow is possible (max (2^N-1)^2 < 2^2N).
//     - The adder carry is kept in C and shifted into ACC MSB, never dropped.
//   Boundary conditions
//     - start while busy=1, including in DONE, is ignored; operands are not re-captured.
//     - start held high continuously restarts in the cycle after DONE, one IDLE cycle per result.
//     - a or b changing during LOAD/CALC/DONE has no effect.
//     - rst mid-operation: next cycle IDLE, done=0, product=0; the partial result is discarded.
//     - a=0 or b=0 gives product=0; a=b=2^N-1 gives (2^N-1)^2.
// STRUCTURE
//   Shared include mult_defs.vh:
//     - state encodings IDLE=2'd0, LOAD=2'd1, CALC=2'd2, DONE=2'd3
//     - default N, counter width CW=$clog2(N)+1
//   Sub-module:
//     - adder_nbit #(N): combinational N-bit adder with carry-out, used in CALC.
//     - FSM, shift register and counter stay in this module.
// TESTING
//   1. rst=1 for 2 cycles with start=1 -> busy=0, done=0, product=8'h00.
//   2. a=4'hF, b=4'hF, start 1 cycle -> done 6 cycles later; product=8'hE1 (225).
//      done is high for exactly one cycle.
//   3. a=9, b=6 -> 8'h36 (54); a=0, b=4'hD -> 8'h00; a=1, b=4'hB -> 8'h0B.
//   4. a=3, b=5, start accepted; start with a=7, b=7 pulsed in CALC and in DONE
//      -> product=8'h0F, no second done.
//   5. a=4'hC, b=4'hA, start; rst=1 in 2nd CALC cycle -> IDLE next cycle, product=0, no done.
//      Restart with the same operands -> 8'h78.
//   6. Exhaustive sweep of all 256 (a,b) pairs, start held high
//      -> each product == a*b, one done per result, 7-cycle period.

Source files
------------

// File: rtl/seq_mult_4x4_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package seq_mult_4x4_pkg;

    // Default operand width; product is twice this, iteration count equals it
    localparam int unsigned MULT_N = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } mult_state_e;

    // Iteration counter width: one spare bit above what N-1 needs
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_mult_4x4_adder.sv
// Combinational W-bit adder with carry-out, used for the partial-product add.
module adder_nbit
    import seq_mult_4x4_pkg::*;
#(
    parameter int unsigned W = MULT_N
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_c_o,
    output logic         cout_c_o
);

    // Zero-extend both operands so the carry lands in the top bit
    assign {cout_c_o, sum_c_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_mult_4x4.sv
// Sequential shift-add unsigned multiplier: N x N -> 2N, one partial product per clock.
module seq_mult_4x4
    import seq_mult_4x4_pkg::*;
#(
    parameter int unsigned N = MULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int unsigned CW = cnt_width(N);

    mult_state_e    state_q;
    logic [N-1:0]   m_q;
    logic [N-1:0]   q_q;
    logic [N-1:0]   acc_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic           done_q;
    logic [2*N-1:0] product_q;

    logic [N-1:0]   addend_c;
    logic [N-1:0]   sum_c;
    logic           carry_c;
    logic [N-1:0]   acc_d;
    logic [N-1:0]   q_d;

    // Multiplicand is added only when the current multiplier LSB is set
    always_comb begin
        addend_c = '0;
        if (q_q[0]) begin
            addend_c = m_q;
        end
    end

    adder_nbit #(
        .W(N)
    ) u_adder (
        .a_i     (acc_q),
        .b_i     (addend_c),
        .sum_c_o (sum_c),
        .cout_c_o(carry_c)
    );

    // Shift {carry, sum, Q} right by one; the carry becomes the new ACC MSB
    always_comb begin
        acc_d = {carry_c, sum_c[N-1:1]};
        q_d   = {sum_c[0], q_q[N-1:1]};
    end

    // Controller, shift register, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        m_q     <= a;
                        q_q     <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Last iteration: publish the product so it is valid alongside done
                    if (cnt_q == CW'(N - 1)) begin
                        product_q <= {acc_d, q_d};
                        done_q    <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_4x4.sv
// Self-checking bench for seq_mult_4x4 against a plain a*b reference with fixed latency.
module tb_seq_mult_4x4;

    localparam int N       = 4;
    localparam int LATENCY = N + 2;  // negedges from accepting edge to done
    localparam int PERIOD  = N + 3;  // done-to-done spacing with start held

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [2*N-1:0] product;

    int checks;
    int errors;

    seq_mult_4x4 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] ref_mult(input logic [N-1:0] x, input logic [N-1:0] y);
        int p;
        p = int'(x) * int'(y);
        return (2*N)'(p);
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 4'hF; b = 4'hF;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (product !== 8'h00) begin errors++; $display("FAIL reset_product got %h want 00", product); end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%b want 0", busy); end
    endtask

    // One isolated operation; operands are scrambled while busy to show they are not re-sampled
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input string name);
        int n;
        logic [2*N-1:0] exp;
        exp = ref_mult(av, bv);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 20) begin
            a = N'($urandom); b = N'($urandom);
            @(negedge clk);
            n++;
        end
        checks++; if (n != LATENCY) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, n, LATENCY); end
        checks++; if (product !== exp) begin errors++; $display("FAIL %s_product got %h want %h", name, product, exp); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_in_done got %b want 1", name, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width got %b want 0", name, done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b want 0", name, busy); end
        checks++; if (product !== exp) begin errors++; $display("FAIL %s_product_hold got %h want %h", name, product, exp); end
    endtask

    task automatic test_max();
        run_op(4'hF, 4'hF, "max");
    endtask

    task automatic test_directed();
        run_op(4'h9, 4'h6, "nine_six");
        run_op(4'h0, 4'hD, "zero_a");
        run_op(4'h1, 4'hB, "one_b");
        run_op(4'h7, 4'h0, "zero_b");
    endtask

    task automatic test_random();
        logic [N-1:0] ra, rb;
        for (int i = 0; i < 10; i++) begin
            ra = N'($urandom); rb = N'($urandom);
            run_op(ra, rb, "random");
        end
    endtask

    // Start pulses in CALC and DONE must be ignored
    task automatic test_start_while_busy();
        int dones;
        a = 4'h3; b = 4'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 16; n++) begin
            if (done === 1'b1) dones++;
            if (n == LATENCY) begin
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_start_done got %b want 1", done); end
            end
            start = (n == 3 || n == LATENCY) ? 1'b1 : 1'b0;
            a = (n == 3 || n == LATENCY) ? 4'h7 : a;
            b = (n == 3 || n == LATENCY) ? 4'h7 : b;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (dones != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", dones); end
        checks++; if (product !== 8'h0F) begin errors++; $display("FAIL busy_start_product got %h want 0f", product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
    endtask

    // Reset in the second CALC cycle discards the operation
    task automatic test_mid_reset();
        int dones;
        a = 4'hC; b = 4'hA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (product !== 8'h00) begin errors++; $display("FAIL midrst_product got %h want 00", product); end
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
        run_op(4'hC, 4'hA, "restart");
    endtask

    // Exhaustive sweep with start held: one result every PERIOD cycles
    task automatic test_back_to_back();
        int n;
        int want_gap;
        logic [N-1:0] pa, pb;
        pa = '0; pb = '0;
        a = pa; b = pb; start = 1'b1;
        want_gap = LATENCY;
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            n = 1;
            while (done !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != want_gap) begin
                errors++;
                $display("FAIL sweep_gap pair=%0d got %0d want %0d", k, n, want_gap);
            end
            checks++;
            if (product !== ref_mult(pa, pb)) begin
                errors++;
                $display("FAIL sweep_product a=%h b=%h got %h want %h", pa, pb, product, ref_mult(pa, pb));
            end
            want_gap = PERIOD;
            pa = N'((k + 1) >> N);
            pb = N'(k + 1);
            a = pa; b = pb;
            if (k == 255) start = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sweep_end_idle got %b want 0", busy); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_max();
        test_directed();
        test_random();
        test_start_while_busy();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
